// File: rtl/sad_pixel_feeder.sv
// rtl/sad_pixel_feeder.sv - SAD producer: reads two pixel blocks, streams |a-b| beats
//
// Walks a BLK_W x BLK_H block in memories A and B, issues one read per cycle
// (bounded so at most two results are ever pending), and streams the 8-bit
// absolute differences over a valid/ready handshake to the SAD accumulator.
//
// Optional feature: define SAD_STRIDE_EN for row/column addressing
// (base + row*STRIDE + col); otherwise addressing is linear (base + i).
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin one block (sampled only when idle)
//   base_a, base_b     block base addresses, captured on start
//   busy, done         block in progress / one-cycle completion pulse
//   rd_en              read strobe to both memories
//   addr_a, addr_b     read addresses
//   rdata_a, rdata_b   read data, valid one cycle after rd_en
//   abs_valid/ready    beat handshake toward the accumulator
//   abs_data, abs_last |a-b| and final-beat marker
module sad_pixel_feeder #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10,
  parameter int BLK_W  = 4,
  parameter int BLK_H  = 4,
  parameter int STRIDE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [PIX_W-1:0]  rdata_a,
  input  logic [PIX_W-1:0]  rdata_b,
  output logic              abs_valid,
  input  logic              abs_ready,
  output logic [PIX_W-1:0]  abs_data,
  output logic              abs_last
);

  localparam int N     = BLK_W * BLK_H;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_a_q, base_b_q, offset;
  logic [CNT_W-1:0]  rd_cnt, pop_cnt;
  logic              inflight;
  logic [1:0]        buf_count;
  logic [PIX_W-1:0]  buf0, buf1, in_abs;
  logic [2:0]        occ;
  logic              pop, pop_buf, push_buf, rd_last;

  assign in_abs = (rdata_a >= rdata_b) ? (rdata_a - rdata_b) : (rdata_b - rdata_a);

  // Returning read data bypasses the empty buffer so the first beat appears
  // in the same cycle the memories answer; if it is not taken it is parked
  // in the buffer and shown unchanged from there on the next cycle.
  assign abs_valid = (buf_count != 2'd0) | inflight;
  assign abs_data  = (buf_count != 2'd0) ? buf0 : (inflight ? in_abs : '0);
  assign abs_last  = abs_valid & (pop_cnt == CNT_W'(N - 1));
  assign pop       = abs_valid & abs_ready;
  assign pop_buf   = pop & (buf_count != 2'd0);
  assign push_buf  = inflight & ~((buf_count == 2'd0) & pop);

  // Reads already issued but not yet consumed must stay below two after
  // this cycle's pop, so the 2-entry buffer can never overflow.
  assign occ     = {1'b0, buf_count} + {2'b00, inflight};
  assign rd_en   = (state == S_RUN) & (occ < (3'd2 + {2'b00, pop}));
  assign rd_last = (rd_cnt == CNT_W'(N - 1));

  assign addr_a = base_a_q + offset;
  assign addr_b = base_b_q + offset;
  assign busy   = (state == S_RUN) | (state == S_DRAIN);
  assign done   = (state == S_DONE);

`ifdef SAD_STRIDE_EN
  localparam int COL_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] row_off_q;

  assign offset = row_off_q + ADDR_W'(col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_off_q <= '0;
    end else if (state == S_IDLE && start) begin
      col_q     <= '0;
      row_off_q <= '0;
    end else if (rd_en) begin
      if (col_q == COL_W'(BLK_W - 1)) begin
        col_q     <= '0;
        row_off_q <= row_off_q + ADDR_W'(STRIDE);
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end
`else
  assign offset = ADDR_W'(rd_cnt);
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (rd_en && rd_last) state_nx = S_DRAIN;
      S_DRAIN: if (pop && abs_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_a_q  <= '0;
      base_b_q  <= '0;
      rd_cnt    <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
      buf_count <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
    end else begin
      inflight <= rd_en;
      if (state == S_IDLE && start) begin
        base_a_q <= base_a;
        base_b_q <= base_b;
        rd_cnt   <= '0;
        pop_cnt  <= '0;
      end else begin
        if (rd_en) rd_cnt  <= rd_cnt + 1'b1;
        if (pop)   pop_cnt <= pop_cnt + 1'b1;
      end
      case (buf_count)
        2'd0: begin
          if (push_buf) begin
            buf0      <= in_abs;
            buf_count <= 2'd1;
          end
        end
        2'd1: begin
          if (pop_buf && push_buf) begin
            buf0 <= in_abs;
          end else if (pop_buf) begin
            buf_count <= 2'd0;
          end else if (push_buf) begin
            buf1      <= in_abs;
            buf_count <= 2'd2;
          end
        end
        default: begin
          if (pop_buf) begin
            buf0 <= buf1;
            if (push_buf) buf1 <= in_abs;
            else          buf_count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_pixel_feeder.sv
// tb/tb_sad_pixel_feeder.sv - self-checking bench for sad_pixel_feeder
module tb_sad_pixel_feeder;

  localparam int N      = 16;
  localparam int BLK_W  = 4;
  localparam int STRIDE = 16;
  localparam int MEM    = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] base_a = '0, base_b = '0;
  logic       busy, done, rd_en, abs_valid, abs_last;
  logic       abs_ready = 1'b0;
  logic [9:0] addr_a, addr_b;
  logic [7:0] rdata_a = '0, rdata_b = '0, abs_data;

  logic [7:0] mem_a [MEM];
  logic [7:0] mem_b [MEM];

  int nvec = 0;
  int nerr = 0;
  int obs_data [N];
  int obs_addr [N];
  int first_pop, last_pop, done_c;

  sad_pixel_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_a(base_a), .base_b(base_b),
    .busy(busy), .done(done), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .abs_valid(abs_valid),
    .abs_ready(abs_ready), .abs_data(abs_data), .abs_last(abs_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rdata_a <= mem_a[addr_a];
      rdata_b <= mem_b[addr_b];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int base, input int r);
`ifdef SAD_STRIDE_EN
    return (base + (r / BLK_W) * STRIDE + (r % BLK_W)) % MEM;
`else
    return (base + r) % MEM;
`endif
  endfunction

  function automatic int exp_abs(input int ba, input int bb, input int k);
    int d;
    d = int'(mem_a[exp_addr(ba, k)]) - int'(mem_b[exp_addr(bb, k)]);
    return (d < 0) ? -d : d;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_addr_a"}, addr_a, 0);
    chk({tag, "_addr_b"}, addr_b, 0);
    chk({tag, "_valid"}, abs_valid, 0);
    chk({tag, "_data"}, abs_data, 0);
    chk({tag, "_last"}, abs_last, 0);
  endtask

  // mode 0: ready always 1; 1: stall 5 cycles at beat 3 then toggle; 2: random
  task automatic run_block(input int ba, input int bb, input int mode,
                           input int rst_at, input int evil_at);
    int c, r, p, stall;
    bit tog, finished, aborted, pop, rdy, prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    r = 0; p = 0; stall = 0; tog = 1'b0; finished = 1'b0; aborted = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    first_pop = -1; last_pop = -1; done_c = -1;
    @(negedge clk);
    base_a = 10'(ba); base_b = 10'(bb); start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_a = 10'($urandom); base_b = 10'($urandom);
    c = 1;
    while (!finished && c < 400) begin
      case (mode)
        0: rdy = 1'b1;
        1: begin
          if (p < 3) rdy = 1'b1;
          else if (stall < 5) begin rdy = 1'b0; stall++; end
          else begin rdy = tog; tog = !tog; end
        end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      abs_ready = rdy;
      start = (c == evil_at);
      if (c == evil_at) begin base_a = 10'($urandom); base_b = 10'($urandom); end
      #1;
      pop = abs_valid && abs_ready;
      if (c == 1) begin
        chk("lat_rd_en", rd_en, 1);
        chk("lat_no_valid", abs_valid, 0);
        chk("busy_run", busy, 1);
      end
      if (prev_stall) begin
        chk("hold_valid", abs_valid, 1);
        chk("hold_data", abs_data, prev_data);
        chk("hold_last", abs_last, prev_last);
      end
      if (rd_en) begin
        chk("rd_window", (r - p - int'(pop)) < 2, 1);
        chk("addr_a", addr_a, exp_addr(ba, r));
        chk("addr_b", addr_b, exp_addr(bb, r));
        if (r < N) obs_addr[r] = int'(addr_a);
        r++;
      end
      if (pop) begin
        if (p < N) begin
          chk("abs_data", abs_data, exp_abs(ba, bb, p));
          chk("abs_last", abs_last, p == N - 1);
          obs_data[p] = int'(abs_data);
        end else begin
          chk("beat_overrun", p, N - 1);
        end
        if (p == 0) first_pop = c;
        last_pop = c;
        p++;
      end
      if (done) begin
        chk("done_timing", c, last_pop + 1);
        chk("done_beats", p, N);
        done_c = c;
        finished = 1'b1;
      end
      if (rst_at >= 0 && p == rst_at && !finished) begin
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        aborted = 1'b1;
        finished = 1'b1;
      end
      prev_stall = abs_valid && !abs_ready;
      prev_data  = abs_data;
      prev_last  = abs_last;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    if (!aborted) begin
      chk("done_seen", finished, 1);
      chk("read_count", r, N);
      chk("beat_count", p, N);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      if (mode == 0) begin
        chk("first_beat_cycle", first_pop, 2);
        chk("last_beat_cycle", last_pop, N + 1);
        chk("done_cycle", done_c, N + 2);
      end
    end
  endtask

  initial begin
    int ext [4];
    for (int i = 0; i < MEM; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) begin
      mem_a[i] = 8'(3 * i);
      mem_b[16 + i] = 8'(i);
    end
    run_block(0, 16, 0, -1, -1);
`ifndef SAD_STRIDE_EN
    for (int i = 0; i < N; i++) chk("linear_2i", obs_data[i], 2 * i);
`endif

    run_block(40, 300, 1, -1, -1);

    ext = '{255, 255, 0, 1};
    mem_a[500] = 8'd0;   mem_b[600] = 8'd255;
    mem_a[501] = 8'd255; mem_b[601] = 8'd0;
    mem_a[502] = 8'd77;  mem_b[602] = 8'd77;
    mem_a[503] = 8'd128; mem_b[603] = 8'd127;
    run_block(500, 600, 2, -1, -1);
`ifndef SAD_STRIDE_EN
    for (int i = 0; i < 4; i++) chk("extreme", obs_data[i], ext[i]);
`endif

    run_block(1020, 1000, 0, -1, 6);
`ifndef SAD_STRIDE_EN
    chk("wrap_first", obs_addr[0], 1020);
    chk("wrap_top", obs_addr[3], 1023);
    chk("wrap_zero", obs_addr[4], 0);
    chk("wrap_end", obs_addr[15], 11);
`endif

    run_block(100, 200, 2, 5, -1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", abs_valid, 0);
    end
    run_block(100, 200, 0, -1, 6);

`ifdef SAD_STRIDE_EN
    run_block(0, 0, 0, -1, -1);
    chk("stride_row1", obs_addr[4], 16);
    chk("stride_row3", obs_addr[12], 48);
    chk("stride_last", obs_addr[15], 51);
`endif

    for (int t = 0; t < 4; t++)
      run_block(int'($urandom_range(0, MEM - 1)), int'($urandom_range(0, MEM - 1)),
                2, -1, int'($urandom_range(2, 10)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
